// File: rtl/sdram_cmd_phy_agent.sv
// SDRAM command PHY agent: decodes AXIS logical commands to registered SDRAM pin levels and
// back-pressures to enforce tRP/tRCD/tMRD/tRFC spacing. Bank-state legality checking is built under SDRAM_CMD_ILLEGAL_CHK_EN.
module sdram_cmd_phy_agent #(
  parameter real clk_period = 7.0,
  parameter real tRP        = 18.0,
  parameter real tRCD       = 18.0,
  parameter real tRFC       = 60.0,
  parameter int  tMRD_cyc   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s_axis_cmd_data,
  input  logic        s_axis_cmd_valid,
  output logic        s_axis_cmd_ready,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [10:0] sdram_addr,
  output logic        cmd_issued,
  output logic        err_illegal_cmd
);

  typedef enum logic [2:0] {
    CMD_ACT = 3'b000,
    CMD_PRE = 3'b001,
    CMD_WR  = 3'b010,
    CMD_RD  = 3'b011,
    CMD_MRS = 3'b100,
    CMD_REF = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  // ceil(t_ns / period), never less than one cycle
  function automatic int ns_to_cyc(input real t_ns, input real period);
    int c;
    c = $rtoi(t_ns / period);
    if ($itor(c) < t_ns / period) c = c + 1;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_RP   = ns_to_cyc(tRP, clk_period);
  localparam int T_RCD  = ns_to_cyc(tRCD, clk_period);
  localparam int T_RFC  = ns_to_cyc(tRFC, clk_period);
  localparam int T_MRD  = (tMRD_cyc < 1) ? 1 : tMRD_cyc;
  localparam int T_MAX  = max2(max2(T_RP, T_RCD), max2(T_RFC, T_MRD));
  localparam int CNT_W  = $clog2(T_MAX + 1);

  localparam logic [3:0] PINS_NOP = 4'b0111;

  logic             rst_pending;
  logic [CNT_W-1:0] wait_cnt;

  cmd_e             cmd_p0;
  logic [1:0]       ba_p0;
  logic [10:0]      addr_p0;
  logic [3:0]       pins_p0;
  logic [CNT_W-1:0] tc_m1_p0;
  logic             vld_p0;
  logic             illegal_p0;

  assign cmd_p0           = cmd_e'(s_axis_cmd_data[2:0]);
  assign addr_p0          = s_axis_cmd_data[13:3];
  assign ba_p0            = s_axis_cmd_data[15:14];
  assign s_axis_cmd_ready = ~rst_pending & (wait_cnt == '0);
  assign vld_p0           = s_axis_cmd_valid & s_axis_cmd_ready;

  // Stage p0: decode the offered beat into pin levels and spacing
  always_comb begin
    pins_p0  = PINS_NOP;
    tc_m1_p0 = '0;
    unique case (cmd_p0)
      CMD_ACT: begin pins_p0 = 4'b0011; tc_m1_p0 = CNT_W'(T_RCD - 1); end
      CMD_PRE: begin pins_p0 = 4'b0010; tc_m1_p0 = CNT_W'(T_RP - 1);  end
      CMD_WR:  pins_p0 = 4'b0100;
      CMD_RD:  pins_p0 = 4'b0101;
      CMD_MRS: begin pins_p0 = 4'b0000; tc_m1_p0 = CNT_W'(T_MRD - 1); end
      CMD_REF: begin pins_p0 = 4'b0001; tc_m1_p0 = CNT_W'(T_RFC - 1); end
      CMD_BST: pins_p0 = 4'b0110;
      CMD_NOP: pins_p0 = PINS_NOP;
    endcase
  end

`ifdef SDRAM_CMD_ILLEGAL_CHK_EN
  logic [3:0] bank_open;

  always_comb begin
    illegal_p0 = 1'b0;
    case (cmd_p0)
      CMD_ACT:          illegal_p0 = bank_open[ba_p0];
      CMD_RD, CMD_WR:   illegal_p0 = ~bank_open[ba_p0];
      CMD_MRS, CMD_REF: illegal_p0 = |bank_open;
      default:          illegal_p0 = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_open <= '0;
    end else if (vld_p0 && !illegal_p0) begin
      if (cmd_p0 == CMD_ACT) begin
        bank_open[ba_p0] <= 1'b1;
      end else if (cmd_p0 == CMD_PRE) begin
        // A10 high means precharge-all
        if (addr_p0[10]) bank_open <= '0;
        else             bank_open[ba_p0] <= 1'b0;
      end
    end
  end
`else
  assign illegal_p0 = 1'b0;
`endif

  // Stage p1: registered pins, spacing counter and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_pending     <= 1'b1;
      wait_cnt        <= '0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= PINS_NOP;
      sdram_ba        <= '0;
      sdram_addr      <= '0;
      cmd_issued      <= 1'b0;
      err_illegal_cmd <= 1'b0;
    end else begin
      rst_pending     <= 1'b0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= PINS_NOP;
      cmd_issued      <= 1'b0;
      err_illegal_cmd <= 1'b0;
      if (vld_p0 && illegal_p0) begin
        err_illegal_cmd <= 1'b1;
      end else if (vld_p0) begin
        wait_cnt <= tc_m1_p0;
        if (cmd_p0 != CMD_NOP) begin
          {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= pins_p0;
          sdram_ba   <= ba_p0;
          sdram_addr <= addr_p0;
          cmd_issued <= 1'b1;
        end
      end else if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_phy_agent.sv
// Bench for sdram_cmd_phy_agent: directed steps plus a randomized phase, checked cycle by
// cycle against a timestamp-based reference model (define SDRAM_CMD_ILLEGAL_CHK_EN to match the DUT build).
module tb_sdram_cmd_phy_agent;

  localparam real P_CLK  = 7.0;
  localparam real P_TRP  = 18.0;
  localparam real P_TRCD = 18.0;
  localparam real P_TRFC = 60.0;
  localparam int  P_TMRD = 2;

  localparam logic [2:0] C_ACT = 3'd0, C_PRE = 3'd1, C_WR = 3'd2, C_RD = 3'd3;
  localparam logic [2:0] C_MRS = 3'd4, C_REF = 3'd5, C_BST = 3'd6, C_NOP = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_axis_cmd_data;
  logic        s_axis_cmd_valid;
  logic        s_axis_cmd_ready;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [10:0] sdram_addr;
  logic        cmd_issued;
  logic        err_illegal_cmd;

  always #5 clk = ~clk;

  sdram_cmd_phy_agent dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_cmd_data  (s_axis_cmd_data),
    .s_axis_cmd_valid (s_axis_cmd_valid),
    .s_axis_cmd_ready (s_axis_cmd_ready),
    .sdram_cs_n       (sdram_cs_n),
    .sdram_ras_n      (sdram_ras_n),
    .sdram_cas_n      (sdram_cas_n),
    .sdram_we_n       (sdram_we_n),
    .sdram_ba         (sdram_ba),
    .sdram_addr       (sdram_addr),
    .cmd_issued       (cmd_issued),
    .err_illegal_cmd  (err_illegal_cmd)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: time stamps instead of counters
  int          cyc = 0;
  int          ready_at = 0;
  bit          ready_known = 0;
  logic [3:0]  m_pins = 4'b0111;
  logic [1:0]  m_ba = '0;
  logic [10:0] m_addr = '0;
  logic        m_iss = 1'b0;
  logic        m_err = 1'b0;
`ifdef SDRAM_CMD_ILLEGAL_CHK_EN
  logic [3:0]  m_bank = '0;
`endif
  int          hs_log[$];

  function automatic int tc(input logic [2:0] c);
    real v;
    case (c)
      C_PRE:   v = $ceil(P_TRP / P_CLK);
      C_ACT:   v = $ceil(P_TRCD / P_CLK);
      C_REF:   v = $ceil(P_TRFC / P_CLK);
      C_MRS:   v = $itor(P_TMRD);
      default: v = 1.0;
    endcase
    if (v < 1.0) v = 1.0;
    return $rtoi(v);
  endfunction

  function automatic logic [3:0] pin_of(input logic [2:0] c);
    case (c)
      C_ACT:   return 4'b0011;
      C_PRE:   return 4'b0010;
      C_WR:    return 4'b0100;
      C_RD:    return 4'b0101;
      C_MRS:   return 4'b0000;
      C_REF:   return 4'b0001;
      C_BST:   return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] c, input logic [1:0] b, input logic [10:0] a);
    return {b, a, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic [15:0] d, output bit acc);
    bit hs;
    bit bad;
    logic [2:0] c;
    logic [1:0] b;
    rst_n = r;
    s_axis_cmd_valid = v;
    s_axis_cmd_data = d;
    if (ready_known) chk("ready", 32'(s_axis_cmd_ready), 32'(cyc >= ready_at));
    hs = r && v && ready_known && (cyc >= ready_at);
    c = d[2:0];
    b = d[15:14];
    bad = 1'b0;
    @(posedge clk);
    cyc++;
    m_pins = 4'b0111;
    m_iss = 1'b0;
    m_err = 1'b0;
    if (!r) begin
      ready_at = cyc + 1;
      ready_known = 1;
      m_ba = '0;
      m_addr = '0;
`ifdef SDRAM_CMD_ILLEGAL_CHK_EN
      m_bank = '0;
`endif
    end else if (hs) begin
      hs_log.push_back(cyc);
`ifdef SDRAM_CMD_ILLEGAL_CHK_EN
      bad = (c == C_ACT && m_bank[b]) || ((c == C_RD || c == C_WR) && !m_bank[b]) ||
            ((c == C_MRS || c == C_REF) && m_bank != 4'd0);
      if (!bad && c == C_ACT) m_bank[b] = 1'b1;
      if (!bad && c == C_PRE) begin
        if (d[13]) m_bank = '0;
        else       m_bank[b] = 1'b0;
      end
`endif
      if (bad) begin
        m_err = 1'b1;
      end else begin
        ready_at = cyc + tc(c) - 1;
        if (c != C_NOP) begin
          m_pins = pin_of(c);
          m_ba = b;
          m_addr = d[13:3];
          m_iss = 1'b1;
        end
      end
    end
    #1;
    chk("pins", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(m_pins));
    chk("ba", 32'(sdram_ba), 32'(m_ba));
    chk("addr", 32'(sdram_addr), 32'(m_addr));
    chk("cmd_issued", 32'(cmd_issued), 32'(m_iss));
    chk("err_illegal_cmd", 32'(err_illegal_cmd), 32'(m_err));
    acc = hs;
  endtask

  task automatic send(input logic [15:0] d);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 40) begin
      tick(1'b1, 1'b1, d, acc);
      n++;
    end
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 16'h0000, acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int e0;
    int gaps[8];
    logic [15:0] cur;
    bit pend;

    // Reset with a PRE-all held valid, then release
    repeat (3) tick(1'b0, 1'b1, mk(C_PRE, 2'd0, 11'h400), acc);
    chk("reset_ready_low", 32'(s_axis_cmd_ready), 32'd0);
    e0 = cyc;
    hs_log.delete();
    send(mk(C_PRE, 2'd0, 11'h400));
    chk("first_accept_cycle", 32'(hs_log[0]), 32'(e0 + 2));
    chk("pre_pins", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h2);
    chk("pre_a10", 32'(sdram_addr[10]), 32'd1);
    idle(2);

    // Init sequence with valid held throughout
    hs_log.delete();
    send(mk(C_PRE, 2'd0, 11'h400));
    send(mk(C_MRS, 2'd0, 11'h030));
    repeat (4) send(mk(C_NOP, 2'd0, 11'h000));
    send(mk(C_REF, 2'd0, 11'h000));
    send(mk(C_REF, 2'd0, 11'h000));
    send(mk(C_NOP, 2'd0, 11'h000));
    gaps = '{3, 2, 1, 1, 1, 1, 9, 9};
    for (int i = 0; i < 8; i++) chk("init_gap", 32'(hs_log[i+1] - hs_log[i]), 32'(gaps[i]));

    // ACT then READ spacing
    hs_log.delete();
    send(mk(C_ACT, 2'd2, 11'h155));
    send(mk(C_RD, 2'd2, 11'h010));
    chk("act_rd_gap", 32'(hs_log[1] - hs_log[0]), 32'd3);
    chk("rd_ba", 32'(sdram_ba), 32'd2);

    // Back-to-back READ, READ, WRITE
    hs_log.delete();
    send(mk(C_RD, 2'd2, 11'h020));
    chk("rd1_issued", 32'(cmd_issued), 32'd1);
    send(mk(C_RD, 2'd2, 11'h021));
    chk("rd2_pins", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h5);
    send(mk(C_WR, 2'd2, 11'h022));
    chk("wr_pins", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h4);
    chk("rrw_gap0", 32'(hs_log[1] - hs_log[0]), 32'd1);
    chk("rrw_gap1", 32'(hs_log[2] - hs_log[1]), 32'd1);

    // Reset in the middle of a REF wait
    send(mk(C_PRE, 2'd0, 11'h400));
    send(mk(C_REF, 2'd0, 11'h000));
    idle(3);
    tick(1'b0, 1'b0, 16'h0000, acc);
    chk("midreset_pins", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h7);
    tick(1'b1, 1'b0, 16'h0000, acc);
    chk("ready_after_reset", 32'(s_axis_cmd_ready), 32'd1);

    // Commands that are illegal when bank tracking is built
    send(mk(C_RD, 2'd1, 11'h004));
`ifdef SDRAM_CMD_ILLEGAL_CHK_EN
    chk("illegal_rd_err", 32'(err_illegal_cmd), 32'd1);
`endif
    idle(1);
    send(mk(C_ACT, 2'd1, 11'h0AA));
    send(mk(C_MRS, 2'd0, 11'h030));
`ifdef SDRAM_CMD_ILLEGAL_CHK_EN
    chk("illegal_mrs_err", 32'(err_illegal_cmd), 32'd1);
`endif
    idle(1);
    send(mk(C_PRE, 2'd0, 11'h400));

    // Randomized phase with AXIS-compliant hold of offered data
    pend = 0;
    cur = '0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(63) == 0) begin
        tick(1'b0, 1'b0, 16'h0000, acc);
        pend = 0;
      end else if (!pend && $urandom_range(3) == 0) begin
        tick(1'b1, 1'b0, 16'($urandom), acc);
      end else begin
        if (!pend) begin
          cur = mk(3'($urandom_range(7)), 2'($urandom_range(3)), 11'($urandom));
          pend = 1;
        end
        tick(1'b1, 1'b1, cur, acc);
        if (acc) pend = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
